// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared constants, frame-order table and state enum for the DB15 joystick transmitter
package joy_db15_pkg;
  localparam int FRAME_LEN = 24;
  localparam int IDX_W = $clog2(FRAME_LEN + 1);
  // Each entry is {player, button bit}: player 0 = joystick1, 1 = joystick2.
  // Button bits: 0 R, 1 L, 2 Dn, 3 Up, 4 A, 5 B, 6 C, 7 D, 8 Start, 9 Sel, 10 E, 11 F.
  localparam logic [4:0] FRAME_MAP [FRAME_LEN] = '{
    5'h07, 5'h06, 5'h05, 5'h04, 5'h00, 5'h01, 5'h02, 5'h03,
    5'h10, 5'h11, 5'h12, 5'h13,
    5'h0b, 5'h0a, 5'h09, 5'h08,
    5'h1b, 5'h1a, 5'h19, 5'h18, 5'h17, 5'h16, 5'h15, 5'h14
  };
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
  // Reorders the two active-high button words into frame order (index 0 at bit 0).
  function automatic logic [FRAME_LEN-1:0] frame_bits(input logic [15:0] j1, input logic [15:0] j2);
    logic [FRAME_LEN-1:0] f;
    for (int i = 0; i < FRAME_LEN; i++)
      f[i] = FRAME_MAP[i][4] ? j2[FRAME_MAP[i][3:0]] : j1[FRAME_MAP[i][3:0]];
    return f;
  endfunction
endpackage

// File: rtl/joy_db15_if.sv
// joy_db15_if: host-side DB15 serial link (shift clock, active-low load, serial data)
interface joy_db15_if;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;
  modport master (output JOY_CLK, output JOY_LOAD, input JOY_DATA);
  modport slave (input JOY_CLK, input JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/joy_db15_sync.sv
// joy_db15_sync: synchronizes JOY_CLK/JOY_LOAD, detects shift-clock rises and delays the load sample to align with them
module joy_db15_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic joy_clk,
  input  logic joy_load_n,
  output logic load_s,
  output logic load_n_q,
  output logic clk_rise
);
  logic [SYNC_STAGES-1:0] cs_q, cs_d, ls_q, ls_d;
  logic cprev_q, cprev_d, rise_q, rise_d, lp1_q, lp1_d, lp2_q, lp2_d;
  // clk_rise is registered, so load_n_q is delayed twice to stay the load sample one clk before the synced rise
  always_comb begin
    cs_d = {cs_q[SYNC_STAGES-2:0], joy_clk};
    ls_d = {ls_q[SYNC_STAGES-2:0], joy_load_n};
    cprev_d = cs_q[SYNC_STAGES-1];
    rise_d = cs_q[SYNC_STAGES-1] & ~cprev_q;
    lp1_d = ls_q[SYNC_STAGES-1];
    lp2_d = lp1_q;
  end
  // synchronizer and edge-detect registers; load resets to released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q <= '0;
      ls_q <= '1;
      cprev_q <= 1'b0;
      rise_q <= 1'b0;
      lp1_q <= 1'b1;
      lp2_q <= 1'b1;
    end else begin
      cs_q <= cs_d;
      ls_q <= ls_d;
      cprev_q <= cprev_d;
      rise_q <= rise_d;
      lp1_q <= lp1_d;
      lp2_q <= lp2_d;
    end
  end
  assign load_s = ls_q[SYNC_STAGES-1];
  assign load_n_q = lp2_q;
  assign clk_rise = rise_q;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: DB15 splitter emulator serializing two joysticks as a 24-bit active-low frame; JOY_DB15_TX_TIMEOUT_EN adds a shift watchdog
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  joy_db15_if.slave   bus,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  output logic        frame_done,
  output logic        busy
);
  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("joy_db15_tx: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end
  logic load_s, load_n_q, clk_rise, qe;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRAME_LEN-1:0] snap_q, snap_d;
  logic data_q, data_d, done_q, done_d, busy_q, busy_d;
`ifdef JOY_DB15_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif
  joy_db15_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .joy_clk(bus.JOY_CLK),
    .joy_load_n(bus.JOY_LOAD),
    .load_s(load_s),
    .load_n_q(load_n_q),
    .clk_rise(clk_rise)
  );
  assign qe = clk_rise & load_n_q;
  // next-state: load overrides everything, then release, shift edges and the optional watchdog
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    snap_d = snap_q;
    busy_d = busy_q;
    done_d = 1'b0;
`ifdef JOY_DB15_TX_TIMEOUT_EN
    wdog_d = '0;
`endif
    if (!load_s) begin
      state_d = S_LOAD;
      idx_d = '0;
      snap_d = frame_bits(joystick1, joystick2);
      busy_d = 1'b0;
    end else if (state_q == S_LOAD) begin
      state_d = S_SHIFT;
      busy_d = 1'b1;
    end else if (state_q == S_SHIFT && qe) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
        state_d = S_DONE;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
`ifdef JOY_DB15_TX_TIMEOUT_EN
    else if (state_q == S_SHIFT) begin
      if (wdog_q == WD_W'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        busy_d = 1'b0;
      end else wdog_d = wdog_q + 1'b1;
    end
`endif
    data_d = (state_d == S_LOAD || state_d == S_SHIFT) ? ~snap_d[idx_d] : 1'b1;
  end
  // state, index, snapshot and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      snap_q <= '0;
      data_q <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef JOY_DB15_TX_TIMEOUT_EN
      wdog_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      data_q <= data_d;
      done_q <= done_d;
      busy_q <= busy_d;
`ifdef JOY_DB15_TX_TIMEOUT_EN
      wdog_q <= wdog_d;
`endif
    end
  end
  assign bus.JOY_DATA = data_q;
  assign frame_done = done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: host-model bench reading DB15 frames and checking them against a button-order reference
module tb_joy_db15_tx;
`ifdef JOY_DB15_TX_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif
  localparam int R = 0, L = 1, DN = 2, UP = 3, A = 4, B = 5, C = 6, D = 7, ST = 8, SE = 9, E = 10, F = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] j1 = '0, j2 = '0;
  logic frame_done, busy;
  int n_cmp = 0, n_err = 0, done_cnt = 0;
  joy_db15_if bus();
  joy_db15_tx #(.SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .joystick1(j1),
    .joystick2(j2),
    .frame_done(frame_done),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  function automatic logic [0:23] model(input logic [15:0] a, input logic [15:0] b);
    return {a[D], a[C], a[B], a[A], a[R], a[L], a[DN], a[UP],
            b[R], b[L], b[DN], b[UP],
            a[F], a[E], a[SE], a[ST],
            b[F], b[E], b[SE], b[ST], b[D], b[C], b[B], b[A]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int nclk, input int chg_at, input logic [15:0] chg_val, input bit rel_edge);
    logic [0:23] snap;
    logic exp_b;
    int d0;
    bus.JOY_LOAD = 1'b0;
    wclk(12);
    snap = model(j1, j2);
    bus.JOY_LOAD = 1'b1;
    if (rel_edge) bus.JOY_CLK = 1'b1;
    d0 = done_cnt;
    wclk(8);
    chk($sformatf("%s busy_after_release", tag), busy, 1);
    if (rel_edge) begin
      bus.JOY_CLK = 1'b0;
      wclk(8);
    end
    for (int k = 0; k < nclk; k++) begin
      if (k == chg_at) j1 = chg_val;
      exp_b = (k < 24) ? ~snap[k] : 1'b1;
      chk($sformatf("%s idx%0d", tag, k), bus.JOY_DATA, exp_b);
      bus.JOY_CLK = 1'b1;
      wclk(8);
      bus.JOY_CLK = 1'b0;
      wclk(8);
    end
    if (nclk >= 24) begin
      chk($sformatf("%s busy_end", tag), busy, 0);
      chk($sformatf("%s data_end", tag), bus.JOY_DATA, 1);
      chk($sformatf("%s done_pulses", tag), done_cnt - d0, 1);
    end
  endtask

  initial begin
    int d0;
    bus.JOY_CLK = 1'b0;
    bus.JOY_LOAD = 1'b1;
    wclk(3);
    chk("reset data", bus.JOY_DATA, 1);
    chk("reset busy", busy, 0);
    chk("reset done", frame_done, 0);
    rst_n = 1'b1;
    wclk(4);
    for (int k = 0; k < 4; k++) begin
      bus.JOY_CLK = 1'b1;
      wclk(8);
      bus.JOY_CLK = 1'b0;
      wclk(8);
      chk("idle edge data", bus.JOY_DATA, 1);
      chk("idle edge busy", busy, 0);
    end
    chk("idle no done", done_cnt, 0);
    j1 = 16'h0001; j2 = 16'h0000;
    run_frame("right", 24, -1, '0, 1'b0);
    j1 = 16'h0F00; j2 = 16'h00F0;
    run_frame("fes_dcba", 24, -1, '0, 1'b0);
    j1 = 16'h0000; j2 = 16'h0000;
    run_frame("midchange", 24, 10, 16'hFFFF, 1'b0);
    run_frame("after_change", 24, -1, '0, 1'b0);
    j1 = 16'h0A5C; j2 = 16'h0C3A;
    run_frame("overrun30", 30, -1, '0, 1'b0);
    j1 = 16'h0123; j2 = 16'h0456;
    run_frame("release_edge", 24, -1, '0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      j1 = 16'($urandom);
      j2 = 16'($urandom);
      run_frame($sformatf("rand%0d", r), 24, -1, '0, 1'b0);
    end
`ifdef JOY_DB15_TX_TIMEOUT_EN
    j1 = 16'h0FFF; j2 = 16'h0FFF;
    bus.JOY_LOAD = 1'b0;
    wclk(12);
    bus.JOY_LOAD = 1'b1;
    d0 = done_cnt;
    wclk(8);
    for (int k = 0; k < 5; k++) begin
      bus.JOY_CLK = 1'b1;
      wclk(8);
      bus.JOY_CLK = 1'b0;
      wclk(8);
    end
    chk("timeout idx5 data", bus.JOY_DATA, 0);
    wclk(TO + 8);
    chk("timeout busy", busy, 0);
    chk("timeout data", bus.JOY_DATA, 1);
    chk("timeout no done", done_cnt - d0, 0);
    j1 = 16'h0080; j2 = 16'h0000;
    run_frame("after_timeout", 24, -1, '0, 1'b0);
`endif
    j1 = 16'h0FFF; j2 = 16'h0FFF;
    bus.JOY_LOAD = 1'b0;
    wclk(12);
    bus.JOY_LOAD = 1'b1;
    wclk(8);
    for (int k = 0; k < 3; k++) begin
      bus.JOY_CLK = 1'b1;
      wclk(8);
      bus.JOY_CLK = 1'b0;
      wclk(8);
    end
    chk("pre_reset data", bus.JOY_DATA, 0);
    chk("pre_reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset data", bus.JOY_DATA, 1);
    chk("async_reset busy", busy, 0);
    chk("async_reset done", frame_done, 0);
    wclk(2);
    rst_n = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      bus.JOY_CLK = 1'b1;
      wclk(8);
      bus.JOY_CLK = 1'b0;
      wclk(8);
      chk("post_reset idle data", bus.JOY_DATA, 1);
    end
    chk("post_reset busy", busy, 0);
    chk("post_reset no done", done_cnt - d0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
